sorted_table_loader: RTL and testbench

//  Write-side partner of the closest-value searcher: accepts an unordered stream of

---
 rtl/sorted_table_loader_if.sv | 23 ++
 rtl/sorted_table_loader.sv | 153 +++++++++++++++
 tb/tb_sorted_table_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sorted_table_loader_if.sv
// Value stream into the table loader and store stream out to the closest-value searcher.
// Handshake: in_data/in_last transfer on a posedge where in_valid && in_ready; the source
// holds them while in_valid && !in_ready. store_valid has no backpressure and is not acknowledged.
interface sorted_table_loader_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             store_valid;
  logic [WIDTH-1:0] store_val;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, store_valid, store_val
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, store_valid, store_val
  );
endinterface

// File: rtl/sorted_table_loader.sv
// Builds an ascending, duplicate-free table by parallel insertion, then streams it
// (each entry held for two cycles) to the searcher, ending with an all-ones sentinel.
module sorted_table_loader #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load_start,
  sorted_table_loader_if.slave  bus,
  output logic                  table_rst,
  output logic                  table_ready,
  output logic                  load_done,
  output logic [CW-1:0]         entry_count,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];
  logic [WIDTH-1:0] ins_table [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             half_q, half_d;
  logic             overflow_q, overflow_d;
  logic             table_ready_q, table_ready_d;
  logic             table_rst_q, table_rst_d;
  logic             load_done_q, load_done_d;
  logic             xfer, is_dup, is_ones, is_full;
  logic [WIDTH-1:0] flush_val;

  // Empty slots hold all-ones, so they always compare greater and shift out naturally.
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (table_q[i] == bus.in_data) is_dup = 1'b1;
    end
    is_ones = (bus.in_data == ONES);
    is_full = (count_q == CW'(DEPTH));
    ins_table[0] = (table_q[0] > bus.in_data) ? bus.in_data : table_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (table_q[i] > bus.in_data)
        ins_table[i] = (table_q[i-1] > bus.in_data) ? table_q[i-1] : bus.in_data;
      else
        ins_table[i] = table_q[i];
    end
  end

  always_comb begin
    flush_val = ONES;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == CW'(i)) flush_val = table_q[i];
    end
  end

  assign xfer = (state_q == FILL) && bus.in_valid;

  always_comb begin
    state_d       = state_q;
    table_d       = table_q;
    count_d       = count_q;
    idx_d         = idx_q;
    half_d        = half_q;
    overflow_d    = overflow_q;
    table_ready_d = table_ready_q;
    table_rst_d   = 1'b0;
    load_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          for (int i = 0; i < DEPTH; i++) table_d[i] = ONES;
          count_d       = '0;
          overflow_d    = 1'b0;
          table_ready_d = 1'b0;
          table_rst_d   = 1'b1;
          state_d       = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          if (!is_dup && !is_ones) begin
            if (is_full) begin
              overflow_d = 1'b1;
            end else begin
              table_d = ins_table;
              count_d = count_q + CW'(1);
            end
          end
          if (bus.in_last) begin
            idx_d   = '0;
            half_d  = 1'b0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        half_d = ~half_q;
        if (half_q) begin
          if (idx_q == count_q) begin
            load_done_d   = 1'b1;
            table_ready_d = 1'b1;
            state_d       = IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= ONES;
      count_q       <= '0;
      idx_q         <= '0;
      half_q        <= 1'b0;
      overflow_q    <= 1'b0;
      table_ready_q <= 1'b0;
      table_rst_q   <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      table_q       <= table_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      half_q        <= half_d;
      overflow_q    <= overflow_d;
      table_ready_q <= table_ready_d;
      table_rst_q   <= table_rst_d;
      load_done_q   <= load_done_d;
    end
  end

  assign bus.in_ready    = (state_q == FILL);
  assign bus.store_valid = (state_q == FLUSH);
  assign bus.store_val   = (state_q == FLUSH) ? flush_val : '0;
  assign table_rst       = table_rst_q;
  assign table_ready     = table_ready_q;
  assign load_done       = load_done_q;
  assign entry_count     = count_q;
  assign overflow        = overflow_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_sorted_table_loader.sv
// Bench for sorted_table_loader (DEPTH=4): directed loads plus random loads checked
// against a queue-based model of the expected sorted store stream.
module tb_sorted_table_loader;
  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          load_start = 1'b0;
  logic          table_rst, table_ready, load_done, overflow;
  logic [CW-1:0] entry_count;
  logic [1:0]    state_dbg;

  sorted_table_loader_if #(.WIDTH(WIDTH)) bus ();

  sorted_table_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_start  (load_start),
    .bus         (bus.slave),
    .table_rst   (table_rst),
    .table_ready (table_ready),
    .load_done   (load_done),
    .entry_count (entry_count),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] stim_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int   exp_count;
  logic exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: first DEPTH distinct non-sentinel values, sorted, each sent twice, then sentinel twice.
  task automatic build_expected();
    logic [WIDTH-1:0] uniq[$];
    int hits[$];
    exp_ovf = 1'b0;
    foreach (stim_q[i]) begin
      hits = uniq.find_index with (item == stim_q[i]);
      if (stim_q[i] == ONES || hits.size() != 0) continue;
      if (uniq.size() == DEPTH) begin
        exp_ovf = 1'b1;
        continue;
      end
      uniq.push_back(stim_q[i]);
    end
    exp_count = uniq.size();
    uniq.sort();
    exp_q.delete();
    foreach (uniq[i]) begin
      exp_q.push_back(uniq[i]);
      exp_q.push_back(uniq[i]);
    end
    exp_q.push_back(ONES);
    exp_q.push_back(ONES);
  endtask

  task automatic start_load();
    @(posedge clk_in) #1 load_start = 1'b1;
    @(posedge clk_in) #1 load_start = 1'b0;
    @(negedge clk_in);
    check("table_rst_pulse", table_rst, 1);
    check("fill_in_ready", bus.in_ready, 1);
    check("fill_table_ready", table_ready, 0);
    check("fill_count_clear", entry_count, 0);
    check("fill_ovf_clear", overflow, 0);
    @(posedge clk_in) #1;
    check("table_rst_once", table_rst, 0);
  endtask

  task automatic send_values(input bit gaps);
    foreach (stim_q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk_in) #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
      bus.in_last  = (i == stim_q.size() - 1);
      @(posedge clk_in) #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_load(input bit gaps, input bit poke_start);
    int cycles;
    int exp_len;
    bit done;
    build_expected();
    exp_len = exp_q.size();
    start_load();
    send_values(gaps);
    cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 2 * (DEPTH + 1) + 4; c++) begin
      @(negedge clk_in);
      if (load_done) begin
        done = 1'b1;
        break;
      end
      cycles++;
      check("flush_valid", bus.store_valid, 1);
      if (exp_q.size() != 0) check("flush_val", bus.store_val, exp_q.pop_front());
      check("flush_count", entry_count, exp_count);
      load_start = (poke_start && c == 1);
    end
    load_start = 1'b0;
    check("flush_len", cycles, exp_len);
    check("load_done_seen", done, 1);
    check("done_store_valid", bus.store_valid, 0);
    check("done_table_ready", table_ready, 1);
    check("done_count", entry_count, exp_count);
    check("done_overflow", overflow, exp_ovf);
    @(negedge clk_in);
    check("load_done_once", load_done, 0);
    check("idle_table_ready", table_ready, 1);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_store_valid", bus.store_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_store_valid"}, bus.store_valid, 0);
    check({tag, "_store_val"}, bus.store_val, 0);
    check({tag, "_table_rst"}, table_rst, 0);
    check({tag, "_table_ready"}, table_ready, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_count"}, entry_count, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    rst_in = 1'b1;

    stim_q = '{12'd300, 12'd100, 12'd200};
    run_load(1'b0, 1'b0);

    stim_q = '{12'd50, 12'd50, 12'd4095, 12'd50};
    run_load(1'b0, 1'b0);

    stim_q = '{12'd9, 12'd8, 12'd7, 12'd6, 12'd5, 12'd4};
    run_load(1'b0, 1'b0);

    stim_q = '{12'd4095};
    run_load(1'b0, 1'b1);

    // Reset during the third flush cycle of a three-entry table.
    stim_q = '{12'd30, 12'd10, 12'd20};
    build_expected();
    start_load();
    send_values(1'b0);
    @(posedge clk_in) #1;
    @(posedge clk_in) #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_mid_valid", bus.store_valid, 1);
    check("rst_mid_val", bus.store_val, 20);
    @(posedge clk_in) #1;
    rst_in = 1'b1;
    check_all_zero("mid_reset");

    stim_q = '{12'd7, 12'd3};
    run_load(1'b1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int n;
      int r;
      n = $urandom_range(1, 8);
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)     stim_q.push_back(ONES);
        else if (r < 6) stim_q.push_back(WIDTH'($urandom_range(0, 7)));
        else            stim_q.push_back(WIDTH'($urandom_range(0, 4094)));
      end
      run_load(1'b1, t[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
